// File: rtl/main_pkg.sv
`default_nettype none
// ============================================================================
// Module      : main_pkg
// Description : Shared types and constants for the main_ctrl arithmetic unit:
//               FSM state encoding, regime codes and datapath sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package main_pkg;

    localparam int W      = 8;
    localparam int NITER  = 8;
    localparam int ITER_W = $clog2(NITER);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        DONE = 3'd3
    } state_t;

    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_SQR  = 2'd1;
    localparam logic [1:0] R_SQRT = 2'd2;
    localparam logic [1:0] R_POP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/main_alu.sv
`default_nettype none
// ============================================================================
// Module      : main_alu
// Description : Combinational single-step datapath. Given the latched regime,
//               operand, running accumulator and iteration index, produces the
//               accumulator value after one CALC step.
// Ports       : i_regime   [1:0]    regime code (R_SQR / R_SQRT / R_POP)
//               i_opnd     [W-1:0]  operand captured in LOAD
//               i_acc      [W-1:0]  current accumulator
//               i_iter     [2:0]    step index 0..NITER-1
//               o_next_acc [W-1:0]  accumulator after this step
// Revision    : 1.0 - initial release
// ============================================================================
module main_alu
    import main_pkg::*;
(
    input  logic [1:0]        i_regime,
    input  logic [W-1:0]      i_opnd,
    input  logic [W-1:0]      i_acc,
    input  logic [ITER_W-1:0] i_iter,
    output logic [W-1:0]      o_next_acc
);

    // Square-root trial bit starts at the MSB of a W/2-bit root.
    localparam logic [W-1:0] c_SQRT_SEED = W'(1) << (W/2 - 1);

    logic [W-1:0]   w_trial;
    logic [2*W-1:0] w_trial_sq;

    always_comb begin
        w_trial    = i_acc | (c_SQRT_SEED >> i_iter);
        w_trial_sq = {{W{1'b0}}, w_trial} * {{W{1'b0}}, w_trial};
        o_next_acc = i_acc;
        case (i_regime)
            // Shift-and-add multiply of opnd by itself, truncated to W bits.
            R_SQR: begin
                if (i_opnd[i_iter]) begin
                    o_next_acc = i_acc + (i_opnd << i_iter);
                end
            end
            // Bit-by-bit root: only the first W/2 steps carry a trial bit.
            R_SQRT: begin
                if ((i_iter < ITER_W'(W/2)) && (w_trial_sq <= {{W{1'b0}}, i_opnd})) begin
                    o_next_acc = w_trial;
                end
            end
            R_POP: begin
                o_next_acc = i_acc + W'(i_opnd[i_iter]);
            end
            default: o_next_acc = i_acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : main_ctrl
// Description : Multi-mode iterative arithmetic unit (square mod 2^W, integer
//               square root, population count). One operation takes LOAD plus
//               NITER CALC steps plus a single DONE cycle.
// Ports       : clk         rising-edge clock
//               rst         asynchronous active-low reset
//               x    [7:0]  operand, sampled in LOAD only
//               on   [1:0]  regime command, 0 keeps the current regime
//               start       level request, honoured only in IDLE
//               y    [7:0]  last result, updated on CALC->DONE
//               s    [2:0]  FSM state code
//               b           busy (LOAD or CALC)
//               active      regime is nonzero
//               regime[1:0] latched regime
//               real_state  {regime, s, iter} debug word
// Revision    : 1.0 - initial release
// ============================================================================
module main_ctrl
    import main_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    input  logic [1:0]   on,
    input  logic         start,
    output logic [W-1:0] y,
    output logic [2:0]   s,
    output logic         b,
    output logic         active,
    output logic [1:0]   regime,
    output logic [7:0]   real_state
);

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_regime;
    logic [W-1:0]        r_opnd;
    logic [W-1:0]        r_acc;
    logic [ITER_W-1:0]   r_iter;
    logic [W-1:0]        r_y;
    logic [W-1:0]        w_next_acc;
    logic [1:0]          w_eff_regime;
    logic                w_last_iter;

    main_alu u_alu (
        .i_regime   (r_regime),
        .i_opnd     (r_opnd),
        .i_acc      (r_acc),
        .i_iter     (r_iter),
        .o_next_acc (w_next_acc)
    );

    // A fresh command seen in IDLE counts immediately for the launch decision.
    assign w_eff_regime = (on != R_NONE) ? on : r_regime;
    assign w_last_iter  = (r_iter == ITER_W'(NITER - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = IDLE;
        case (r_state)
            IDLE:    w_state_next = (start && (w_eff_regime != R_NONE)) ? LOAD : IDLE;
            LOAD:    w_state_next = CALC;
            CALC:    w_state_next = w_last_iter ? DONE : CALC;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath registers; undefined state codes leave everything untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regime <= R_NONE;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_iter   <= '0;
            r_y      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (on != R_NONE) begin
                        r_regime <= on;
                    end
                end
                LOAD: begin
                    r_opnd <= x;
                    r_acc  <= '0;
                    r_iter <= '0;
                end
                CALC: begin
                    r_acc  <= w_next_acc;
                    r_iter <= r_iter + ITER_W'(1);
                    if (w_last_iter) begin
                        r_y <= w_next_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y          = r_y;
    assign s          = r_state;
    assign b          = (r_state == LOAD) || (r_state == CALC);
    assign active     = (r_regime != R_NONE);
    assign regime     = r_regime;
    assign real_state = {r_regime, r_state, r_iter};

endmodule
`default_nettype wire

// File: tb/tb_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_ctrl
// Description : Self-checking bench for main_ctrl. Expected results are
//               queued when an operation is launched and compared when the
//               DUT reaches DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [1:0] on;
    logic       start;
    logic [7:0] y;
    logic [2:0] s;
    logic       b;
    logic       active;
    logic [1:0] regime;
    logic [7:0] real_state;

    int n_checks;
    int n_pass;
    int sb[$];
    int m_regime;

    main_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .on         (on),
        .start      (start),
        .y          (y),
        .s          (s),
        .b          (b),
        .active     (active),
        .regime     (regime),
        .real_state (real_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int model(input int rg, input int xv);
        int r;
        r = 0;
        case (rg)
            1: r = (xv * xv) % 256;
            2: for (int i = 0; i < 16; i++) if (i * i <= xv) r = i;
            3: for (int i = 0; i < 8; i++) r += (xv >> i) & 1;
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch one operation from IDLE and check its timing and result.
    task automatic do_op(input logic [1:0] cmd, input logic [7:0] xv);
        int n;
        int exp;
        on    = cmd;
        x     = xv;
        start = 1'b1;
        if (cmd != 2'd0) m_regime = cmd;
        sb.push_back(model(m_regime, xv));
        tick();
        check_value("launch_s", s, 1);
        check_value("launch_b", b, 1);
        check_value("launch_regime", regime, m_regime);
        check_value("launch_active", active, 1);
        check_value("launch_real_state", real_state, m_regime * 64 + 8);
        start = 1'b0;
        on    = 2'd0;
        n = 0;
        while (s != 3'd3 && n < 20) begin
            tick();
            n++;
        end
        check_value("latency", n, 9);
        exp = sb.pop_front();
        check_value("result", y, exp);
        check_value("done_b", b, 0);
        tick();
        check_value("idle_s", s, 0);
        check_value("y_hold", y, exp);
    endtask

    initial begin
        int k;
        int t1;
        int t2;
        int ndone;
        int exp;

        n_checks = 0;
        n_pass   = 0;
        m_regime = 0;
        rst   = 1'b0;
        on    = 2'd2;
        start = 1'b0;
        x     = 8'd0;

        // Reset with a pending command present.
        tick();
        tick();
        check_value("rst_y", y, 0);
        check_value("rst_s", s, 0);
        check_value("rst_b", b, 0);
        check_value("rst_regime", regime, 0);
        check_value("rst_active", active, 0);
        check_value("rst_real_state", real_state, 0);
        on  = 2'd0;
        rst = 1'b1;
        tick();
        check_value("rel_s", s, 0);
        check_value("rel_regime", regime, 0);
        check_value("rel_active", active, 0);

        // start with no regime selected is ignored.
        start = 1'b1;
        x     = 8'd13;
        tick();
        tick();
        tick();
        check_value("noreg_s", s, 0);
        check_value("noreg_b", b, 0);
        check_value("noreg_y", y, 0);

        // Regime 1 selected while start is already high launches directly.
        do_op(2'd1, 8'd13);
        do_op(2'd0, 8'd5);
        do_op(2'd0, 8'd255);
        do_op(2'd2, 8'd13);
        do_op(2'd0, 8'd255);
        do_op(2'd0, 8'd0);
        do_op(2'd3, 8'd13);
        do_op(2'd0, 8'd255);

        // Continuous operation: regime change requested mid-CALC takes
        // effect on the next operation only.
        on       = 2'd1;
        x        = 8'd200;
        start    = 1'b1;
        m_regime = 1;
        sb.push_back(model(1, 200));
        k = 0;
        t1 = 0;
        t2 = 0;
        ndone = 0;
        while (ndone < 2 && k < 40) begin
            tick();
            k++;
            if (k == 4) begin
                on = 2'd2;
                m_regime = 2;
                sb.push_back(model(2, 200));
            end
            if (s == 3'd3) begin
                ndone++;
                exp = sb.pop_front();
                check_value("cont_result", y, exp);
                if (ndone == 1) t1 = k;
                else begin
                    t2 = k;
                    start = 1'b0;
                    on    = 2'd0;
                end
            end
        end
        check_value("cont_done_count", ndone, 2);
        check_value("cont_period", t2 - t1, 11);
        check_value("cont_regime", regime, 2);
        tick();
        check_value("cont_idle_s", s, 0);

        // Asynchronous reset in the middle of CALC.
        on    = 2'd3;
        x     = 8'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        on    = 2'd0;
        tick();
        tick();
        tick();
        check_value("abort_pre_s", s, 2);
        #2 rst = 1'b0;
        #1;
        check_value("abort_y", y, 0);
        check_value("abort_s", s, 0);
        check_value("abort_b", b, 0);
        check_value("abort_regime", regime, 0);
        check_value("abort_active", active, 0);
        m_regime = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check_value("post_abort_s", s, 0);
        check_value("post_abort_y", y, 0);
        check_value("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
